// File: rtl/filtro_pkg.sv
// Shared definitions for the band-pass filter cascade and its controller.
// State encoding, term-select width and fixed-point defaults live here.
package filtro_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        SETTLE,
        SHIFT,
        LOAD,
        DONE
    } state_e;

    localparam int SEL_W      = 2;
    localparam int MAX_TERMS  = 1 << SEL_W;
    localparam int MAX_SETTLE = 15;

    localparam int Width     = 22;
    localparam int Presicion = 14;

    function automatic logic is_busy(state_e s);
        return (s == MAC) || (s == SETTLE) ||
               (s == SHIFT) || (s == LOAD);
    endfunction

endpackage

// File: rtl/filtro_secuenciador_control_if.sv
// Request/strobe bundle between the sample-timing logic,
// the sequencer and the filter cascade.
interface filtro_secuenciador_control_if
    import filtro_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             run;
    logic             sample_req;
    logic             clr_overrun;
    logic             enable1;
    logic             enable2;
    logic             enable3;
    logic [SEL_W-1:0] Sel_Muxes;
    logic             busy;
    logic             yk_valid;
    logic             overrun;
    logic [CNT_W-1:0] sample_count;

    modport master (
        output run, sample_req, clr_overrun,
        input  enable1, enable2, enable3, Sel_Muxes,
        input  busy, yk_valid, overrun, sample_count
    );

    modport slave (
        input  run, sample_req, clr_overrun,
        output enable1, enable2, enable3, Sel_Muxes,
        output busy, yk_valid, overrun, sample_count
    );
endinterface

// File: rtl/filtro_contador_muestras.sv
// Completed-sample counter; wraps silently at 2^CNT_W.
module filtro_contador_muestras #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/filtro_secuenciador_control.sv
// Per-sample micro-sequencer for the recursive band-pass cascade:
// MAC terms, settle, shift, load, then a yk_valid pulse.
module filtro_secuenciador_control
    import filtro_pkg::*;
#(
    parameter int NUM_TERMS     = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input logic clk150kHz,
    input logic reset,
    filtro_secuenciador_control_if.slave bus
);
    if (NUM_TERMS < 1 || NUM_TERMS > MAX_TERMS) begin : g_bad_terms
        $error("NUM_TERMS out of range 1..4");
    end
    if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > MAX_SETTLE) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range 0..15");
    end
    if (Presicion >= Width) begin : g_bad_fixp
        $error("fixed-point fraction must be narrower than the word");
    end

    localparam logic [SEL_W-1:0] LAST_TERM   = SEL_W'(NUM_TERMS - 1);
    localparam logic [3:0]       LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] term_q, term_d;
    logic [3:0]       settle_q, settle_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             en1_q, en2_q, en3_q, busy_q, yk_q;
    logic             en1_d, en2_d, en3_d, busy_d, yk_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             start, at_boundary, ovr_set;

    assign at_boundary = (state_q == IDLE) || (state_q == DONE);
    assign start = bus.run && (bus.sample_req || pending_q);

    always_comb begin
        state_d  = state_q;
        term_d   = term_q;
        settle_d = settle_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = MAC;
                    term_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                if (term_q == LAST_TERM) begin
                    settle_d = '0;
                    state_d  = (SETTLE_CYCLES > 0) ? SETTLE : SHIFT;
                end else begin
                    term_d = term_q + 1'b1;
                end
            end
            SETTLE: begin
                if (settle_q == LAST_SETTLE) state_d = SHIFT;
                else settle_d = settle_q + 1'b1;
            end
            SHIFT:   state_d = LOAD;
            LOAD:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // One-deep request buffer; a second request while busy is lost.
    always_comb begin
        pending_d = pending_q;
        ovr_set   = 1'b0;
        if (!bus.run) begin
            pending_d = 1'b0;
        end else if (at_boundary) begin
            if (start) pending_d = 1'b0;
        end else if (bus.sample_req) begin
            if (pending_q) ovr_set   = 1'b1;
            else           pending_d = 1'b1;
        end
        overrun_d = ovr_set || (overrun_q && !bus.clr_overrun);
    end

    always_comb begin
        en1_d  = (state_d == MAC);
        en2_d  = (state_d == SHIFT);
        en3_d  = (state_d == LOAD);
        yk_d   = (state_d == DONE);
        busy_d = is_busy(state_d);
        sel_d  = en1_d ? term_d : '0;
    end

    always_ff @(posedge clk150kHz or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            term_q    <= '0;
            settle_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            en1_q     <= 1'b0;
            en2_q     <= 1'b0;
            en3_q     <= 1'b0;
            busy_q    <= 1'b0;
            yk_q      <= 1'b0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            term_q    <= term_d;
            settle_q  <= settle_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            en1_q     <= en1_d;
            en2_q     <= en2_d;
            en3_q     <= en3_d;
            busy_q    <= busy_d;
            yk_q      <= yk_d;
            sel_q     <= sel_d;
        end
    end

    filtro_contador_muestras #(
        .CNT_W (CNT_W)
    ) u_contador (
        .clk     (clk150kHz),
        .rst_n   (reset),
        .en_i    (yk_d),
        .count_o (bus.sample_count)
    );

    assign bus.enable1   = en1_q;
    assign bus.enable2   = en2_q;
    assign bus.enable3   = en3_q;
    assign bus.Sel_Muxes = sel_q;
    assign bus.busy      = busy_q;
    assign bus.yk_valid  = yk_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_filtro_secuenciador_control.sv
// Bench for the sequencer: default build (a) and NUM_TERMS=1/SETTLE=0/CNT_W=4 (b).
module tb_filtro_secuenciador_control;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    filtro_secuenciador_control_if #(.CNT_W(16)) ifa ();
    filtro_secuenciador_control_if #(.CNT_W(4))  ifb ();

    filtro_secuenciador_control #(
        .NUM_TERMS(4), .SETTLE_CYCLES(1), .CNT_W(16)
    ) dut_a (
        .clk150kHz (clk),
        .reset     (reset),
        .bus       (ifa.slave)
    );

    filtro_secuenciador_control #(
        .NUM_TERMS(1), .SETTLE_CYCLES(0), .CNT_W(4)
    ) dut_b (
        .clk150kHz (clk),
        .reset     (reset),
        .bus       (ifb.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model: a live sample is just "cycles since it started".
    int m_act[2];
    int m_ph[2];
    int m_cnt[2];
    bit m_pend[2];
    bit m_ovr[2];

    function automatic int nt(int i);
        return (i == 0) ? 4 : 1;
    endfunction
    function automatic int st(int i);
        return (i == 0) ? 1 : 0;
    endfunction
    function automatic int cmask(int i);
        return (i == 0) ? 32'hFFFF : 32'hF;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] in_of(int i);
        if (i == 0) return {ifa.run, ifa.sample_req, ifa.clr_overrun};
        return {ifb.run, ifb.sample_req, ifb.clr_overrun};
    endfunction

    task automatic model_clear(int i);
        m_act[i]  = 0;
        m_ph[i]   = 0;
        m_cnt[i]  = 0;
        m_pend[i] = 0;
        m_ovr[i]  = 0;
    endtask

    task automatic model_step(int i);
        int L;
        bit r, q, c, start, set;
        {r, q, c} = in_of(i);
        if (!reset) begin
            model_clear(i);
            return;
        end
        L = nt(i) + st(i) + 3;
        start = r && (q || m_pend[i]);
        set = 0;
        if (m_act[i] == 0 || m_ph[i] == L) begin
            if (start) begin
                m_act[i]  = 1;
                m_ph[i]   = 1;
                m_pend[i] = 0;
            end else begin
                m_act[i] = 0;
            end
        end else begin
            m_ph[i]++;
            if (r && q) begin
                if (m_pend[i]) set = 1;
                else m_pend[i] = 1;
            end
        end
        if (!r) m_pend[i] = 0;
        m_ovr[i] = set || (m_ovr[i] && !c);
        if (m_act[i] != 0 && m_ph[i] == L)
            m_cnt[i] = (m_cnt[i] + 1) & cmask(i);
    endtask

    // {enable1, enable2, enable3, Sel_Muxes, busy, yk_valid, overrun}
    function automatic logic [7:0] exp_out(int i);
        int p, n, s;
        logic e1, e2, e3, bz, yk;
        logic [1:0] sel;
        p = m_ph[i];
        n = nt(i);
        s = st(i);
        if (m_act[i] == 0) return {7'b0, m_ovr[i]};
        e1  = (p >= 1) && (p <= n);
        sel = e1 ? 2'(p - 1) : 2'd0;
        e2  = (p == n + s + 1);
        e3  = (p == n + s + 2);
        yk  = (p == n + s + 3);
        bz  = (p < n + s + 3);
        return {e1, e2, e3, sel, bz, yk, m_ovr[i]};
    endfunction

    function automatic logic [7:0] dut_out(int i);
        if (i == 0)
            return {ifa.enable1, ifa.enable2, ifa.enable3, ifa.Sel_Muxes,
                    ifa.busy, ifa.yk_valid, ifa.overrun};
        return {ifb.enable1, ifb.enable2, ifb.enable3, ifb.Sel_Muxes,
                ifb.busy, ifb.yk_valid, ifb.overrun};
    endfunction

    function automatic logic [31:0] dut_cnt(int i);
        if (i == 0) return 32'(ifa.sample_count);
        return 32'(ifb.sample_count);
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("out%0d", i), dut_out(i), exp_out(i));
            chk($sformatf("cnt%0d", i), dut_cnt(i), 32'(m_cnt[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(int i, bit r, bit q, bit c);
        if (i == 0) begin
            ifa.run = r; ifa.sample_req = q; ifa.clr_overrun = c;
        end else begin
            ifb.run = r; ifb.sample_req = q; ifb.clr_overrun = c;
        end
    endtask

    task automatic pulse(int i, bit r);
        set_in(i, r, 1'b1, 1'b0);
        tick();
        set_in(i, r, 1'b0, 1'b0);
    endtask

    // Cycles from the request edge to yk_valid, bounded.
    task automatic latency(int i, int limit, output int n);
        pulse(i, 1'b1);
        n = 1;
        while (dut_out(i)[1] !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    int lat;

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0);
        set_in(1, 0, 0, 0);
        model_clear(0);
        model_clear(1);
        @(negedge clk);
        check_all();
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();

        // single sample, default build
        set_in(0, 1, 0, 0);
        latency(0, 20, lat);
        chk("lat_a", 32'(lat), 32'd8);
        chk("cnt_one", dut_cnt(0), 32'd1);
        repeat (3) tick();

        // reset in cycle 3 of a sequence
        pulse(0, 1'b1);
        repeat (2) tick();
        #1 reset = 1'b0;
        #1;
        chk("async_rst_out", {24'd0, dut_out(0)}, 32'd0);
        chk("async_rst_cnt", dut_cnt(0), 32'd0);
        model_clear(0);
        model_clear(1);
        repeat (2) tick();
        reset = 1'b1;
        repeat (10) tick();
        chk("post_rst_busy", {31'd0, ifa.busy}, 32'd0);

        // 20 back-to-back samples
        for (int k = 0; k < 20; k++) begin
            pulse(0, 1'b1);
            repeat (7) tick();
        end
        repeat (5) tick();
        chk("b2b_cnt", dut_cnt(0), 32'd20);
        chk("b2b_ovr", {31'd0, ifa.overrun}, 32'd0);

        // requests at 0, 2, 3: one pending, one lost
        pulse(0, 1'b1);
        tick();
        pulse(0, 1'b1);
        pulse(0, 1'b1);
        repeat (16) tick();
        chk("ovr_set", {31'd0, ifa.overrun}, 32'd1);
        set_in(0, 1, 0, 1);
        tick();
        set_in(0, 1, 0, 0);
        chk("ovr_clr", {31'd0, ifa.overrun}, 32'd0);

        // run low ignores requests; dropping run mid-MAC still completes
        set_in(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            pulse(0, 1'b0);
            tick();
        end
        set_in(0, 1, 0, 0);
        repeat (10) tick();
        chk("run0_busy", {31'd0, ifa.busy}, 32'd0);
        chk("run0_ovr", {31'd0, ifa.overrun}, 32'd0);
        pulse(0, 1'b1);
        tick();
        set_in(0, 0, 0, 0);
        lat = 2;
        while (ifa.yk_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("run_drop_lat", 32'(lat), 32'd8);

        // minimal build: 17 samples wrap a 4-bit counter to 1
        set_in(1, 1, 0, 0);
        latency(1, 10, lat);
        chk("lat_b", 32'(lat), 32'd4);
        for (int k = 0; k < 16; k++) begin
            pulse(1, 1'b1);
            repeat (3) tick();
        end
        repeat (4) tick();
        chk("wrap_b", dut_cnt(1), 32'd1);

        // random traffic on both builds
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++)
                set_in(i, $urandom_range(0, 9) != 0,
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) reset = 1'b0;
            else reset = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/filtro_secuenciador_control.md
Name: filtro_secuenciador_control

Overview:
- Control sequencer that drives the enable/select interface of the cascaded recursive band-pass filter datapath: enable1 (MAC accumulate), enable2 (delay-line shift), enable3 (output register load), Sel_Muxes (term select).
- Turns one sample-request pulse into the fixed per-sample micro-sequence and reports completion with yk_valid.
- Sits between the ADC sample-timing logic and the filter cascade, in the clk150kHz domain.

Parameters:
- NUM_TERMS, 4, number of MAC terms per sample, legal range 1..4; Sel_Muxes counts 0..NUM_TERMS-1.
- SETTLE_CYCLES, 1, idle cycles between the last MAC and the shift, legal range 0..15; covers the cascade settling time.
- CNT_W, 16, width of sample_count.

Ports:
- clk150kHz  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  1 = accept sample requests.
- sample_req  input  1  single-cycle pulse requesting one filter sample.
- clr_overrun  input  1  synchronous clear of the overrun flag.
- enable1  output  1  accumulate strobe to the filters.
- enable2  output  1  delay-line shift strobe.
- enable3  output  1  output-register load strobe.
- Sel_Muxes  output  2  term select for the filter multiplexers.
- busy  output  1  high while a sequence is in progress (MAC, SETTLE, SHIFT, LOAD states).
- yk_valid  output  1  one-cycle pulse; yk of the filter is valid.
- overrun  output  1  sticky; a request was lost.
- sample_count  output  CNT_W  number of completed samples, wraps modulo 2^CNT_W.

Behaviour:
- All outputs are registered. While reset=0, every output is 0 immediately and asynchronously, the state is IDLE and the pending flag is cleared. Reset asserted mid-sequence aborts the sequence, with no partial strobes afterwards.
- States and transitions:
  - IDLE -> MAC when a start condition is seen (defined below).
  - MAC lasts NUM_TERMS cycles. enable1=1 throughout. Sel_Muxes=0,1,...,NUM_TERMS-1 on successive cycles.
  - MAC -> SETTLE if SETTLE_CYCLES>0, otherwise MAC -> SHIFT.
  - SETTLE lasts SETTLE_CYCLES cycles. All enables 0. Sel_Muxes holds 0.
  - SHIFT lasts 1 cycle. enable2=1.
  - LOAD lasts 1 cycle. enable3=1.
  - DONE lasts 1 cycle. yk_valid=1, busy=0, sample_count increments.
  - DONE -> MAC if a start condition holds, otherwise DONE -> IDLE.
- Start condition, evaluated in IDLE or DONE: run=1 and (sample_req=1 or pending=1). Starting a sequence clears pending.
- Timing: a request sampled at edge k gives enable1 in cycles k+1..k+NUM_TERMS. enable2 is at k+NUM_TERMS+SETTLE_CYCLES+1, enable3 at +2, yk_valid at +3. With defaults: enable1 at 1-4, enable2 at 6, enable3 at 7, yk_valid at 8.
- Minimum request period is NUM_TERMS+SETTLE_CYCLES+3 cycles (default 8) when requests are served back-to-back through DONE.
- At most one enable output is high in any cycle. Sel_Muxes is 0 outside MAC.
- Request while busy (MAC/SETTLE/SHIFT/LOAD):
  - pending=0: set pending=1 (one-deep buffer).
  - pending=1: request is dropped and overrun is set to 1.
- overrun stays high until clr_overrun=1. If clr_overrun and a new overrun event occur in the same cycle, set wins.
- run=0: new requests are ignored (no pending, no overrun), pending is cleared, and any in-progress sequence completes normally.
- sample_count wraps from 2^CNT_W-1 to 0 with no flag.
- A NUM_TERMS or SETTLE_CYCLES value outside its legal range is a configuration error and must be flagged at elaboration.

Decomposition:
- Shared package filtro_pkg: state encoding constants (IDLE, MAC, SETTLE, SHIFT, LOAD, DONE), the Sel_Muxes width (2), and the filter fixed-point defaults (Width=22, Presicion=14), so datapath and controller agree.
- One natural sub-module: filtro_contador_muestras, the wrapping sample_count counter with its increment enable.
- The FSM, the term counter and the pending/overrun logic stay in this module.

Test Plan:
- Defaults, reset released, run=1, one sample_req at cycle 0 -> enable1 high cycles 1-4 with Sel_Muxes 0,1,2,3; enable2 at 6; enable3 at 7; yk_valid at 8; sample_count=1.
- Requests every 8 cycles, 20 samples -> no idle gap (DONE -> MAC), overrun=0, sample_count=20.
- Requests at cycles 0, 2 and 3 -> the cycle-2 request is served from DONE (enable1 again at 9); the cycle-3 request sets overrun=1; clr_overrun pulse -> overrun=0.
- reset driven low at cycle 3 of a sequence -> all outputs 0 in the same cycle; after release, no strobes until a new request; sample_count=0.
- run=0 with requests pulsed, then run=1 with no requests -> no sequence starts, overrun stays 0; run dropped mid-MAC -> the sequence still completes with yk_valid.
- NUM_TERMS=1, SETTLE_CYCLES=0 -> enable1 at 1 (Sel_Muxes=0), enable2 at 2, enable3 at 3, yk_valid at 4; CNT_W=4 run for 17 samples -> sample_count wraps to 1.
